// File: rtl/wl_sortn.sv
// wl_sortn: pipelined N-input odd-even transposition sorter with valid/stall, median/max/min taps, optional WL_SORTN_INDEX_EN tags
module wl_sortn #(
  parameter int DW = 8,
  parameter int N = 9,
  parameter int ORDER = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic vin,
  input  logic [N*DW-1:0] din,
  output logic vout,
  output logic [N*DW-1:0] dout,
  output logic [DW-1:0] dmed,
  output logic [DW-1:0] dmax,
  output logic [DW-1:0] dmin
`ifdef WL_SORTN_INDEX_EN
  ,
  output logic [N*$clog2(N)-1:0] dout_idx
`endif
);
`ifdef WL_SORTN_INDEX_EN
  localparam int IW = $clog2(N);
`endif
  localparam int MI = (N - 1) / 2;
  for (genvar s = 0; s < N; s++) begin : st
    logic [N*DW-1:0] pin, nxt, q;
    logic vi, v;
`ifdef WL_SORTN_INDEX_EN
    logic [N*IW-1:0] tin, tnx, t;
`endif
    if (s == 0) begin : g_in
      assign pin = din;
      assign vi = vin;
`ifdef WL_SORTN_INDEX_EN
      for (genvar i = 0; i < N; i++) begin : g_tag
        assign tin[i*IW +: IW] = IW'(i);
      end
`endif
    end else begin : g_ch
      assign pin = st[s-1].q;
      assign vi = st[s-1].v;
`ifdef WL_SORTN_INDEX_EN
      assign tin = st[s-1].t;
`endif
    end
    // compare-exchange on pairs starting at index s%2; equal values stay put so ties are stable
    always_comb begin
      nxt = pin;
`ifdef WL_SORTN_INDEX_EN
      tnx = tin;
`endif
      for (int j = s % 2; j < N - 1; j += 2)
        if (ORDER != 0 ? pin[j*DW +: DW] > pin[(j+1)*DW +: DW] : pin[j*DW +: DW] < pin[(j+1)*DW +: DW]) begin
          nxt[j*DW +: DW] = pin[(j+1)*DW +: DW];
          nxt[(j+1)*DW +: DW] = pin[j*DW +: DW];
`ifdef WL_SORTN_INDEX_EN
          tnx[j*IW +: IW] = tin[(j+1)*IW +: IW];
          tnx[(j+1)*IW +: IW] = tin[j*IW +: IW];
`endif
        end
    end
    // stage register: data loads on every enabled cycle, valid rides alongside
    always_ff @(posedge clk)
      if (rst) begin
        q <= '0;
        v <= 1'b0;
`ifdef WL_SORTN_INDEX_EN
        t <= '0;
`endif
      end else if (ce) begin
        q <= nxt;
        v <= vi;
`ifdef WL_SORTN_INDEX_EN
        t <= tnx;
`endif
      end
  end
  assign vout = st[N-1].v;
  assign dout = st[N-1].q;
  assign dmed = dout[MI*DW +: DW];
  assign dmax = ORDER != 0 ? dout[(N-1)*DW +: DW] : dout[0 +: DW];
  assign dmin = ORDER != 0 ? dout[0 +: DW] : dout[(N-1)*DW +: DW];
`ifdef WL_SORTN_INDEX_EN
  assign dout_idx = st[N-1].t;
`endif
endmodule

// File: doc/wl_sortn.md
Name: wl_sortn

Overview:
- Parametrised N-input sorter built as a pipelined odd-even transposition network. It is the successor to the fixed 3-input sorter.
- Used in the Canny datapath for 3x3 window statistics (median filter, local max/min) and for any N-element ordering.
- Adds valid tracking, stall, selectable order, a median tap and stable tie handling.

Parameters:
- DW, 8, element width in bits, unsigned.
- N, 9, element count; legal range 2..32.
- ORDER, 1, 1 = largest element in the top slice; 0 = smallest element in the top slice.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- ce  in  1  pipeline enable; 0 stalls every stage.
- vin  in  1  din is valid this cycle.
- din  in  N*DW  element i is din[i*DW +: DW].
- vout  out  1  dout, dmed, dmax and dmin are valid.
- dout  out  N*DW  sorted vector, element i is dout[i*DW +: DW].
- dmed  out  DW  median: sorted element floor((N-1)/2).
- dmax  out  DW  maximum of the sorted set.
- dmin  out  DW  minimum of the sorted set.

Behaviour:
- Reset: one clk and one active-high synchronous reset input. While rst=1 at a rising edge, all stage data registers go to 0 and all stage valid bits go to 0. vout, dout, dmed, dmax and dmin therefore read 0 on the cycle after reset. rst overrides ce.
- Structure: N stages, s = 0..N-1, each registered. Stage 0 takes din.
  - Even s compares pairs (0,1),(2,3),…
  - Odd s compares pairs (1,2),(3,4),…
  - An unpaired edge element passes through unchanged.
- Compare-exchange on pair (j, j+1):
  - ORDER=1: swap only if e[j] > e[j+1]. The larger value moves to the higher index.
  - ORDER=0: swap only if e[j] < e[j+1].
  - Equal values never swap, so ties keep their original relative order.
- Latency: exactly N enabled cycles from vin/din to vout/dout. Throughput is one vector per enabled cycle, with no bubbles.
- Valid: a valid bit travels alongside the data through every stage. Stage data registers load on every ce=1 cycle whether or not the valid bit is set. When vout=0, downstream must ignore the data.
- ce=0: every data and valid register holds. Outputs are unchanged and vin/din are ignored. Stalls can be any length. Releasing ce resumes with no loss or duplication.
- Taps:
  - dmed = dout slice floor((N-1)/2); for N=9 that is slice 4.
  - ORDER=1: dmax = slice N-1, dmin = slice 0.
  - ORDER=0: dmax = slice 0, dmin = slice N-1.
  - All taps come from the final register stage: no extra register and no extra latency.
- Arithmetic: unsigned magnitude compare only. No width growth.
- Reset mid-stream: all in-flight vectors are discarded. The first vin after rst deasserts appears N enabled cycles later.
- N=2 reduces to a single compare stage plus one pass stage, giving latency 2.

Optional Feature:
- Macro: WL_SORTN_INDEX_EN.
- When defined, an extra output port dout_idx (out, N*IW, with IW = clog2(N)) is added.
  - Each input element carries tag = i, which is swapped together with its data at every compare-exchange.
  - dout_idx slice k gives the original input position of dout slice k.
  - Reset value is 0. Tags obey the same ce/valid rules as the data.
- When not defined, the port and the tag registers do not exist and there is no area cost.

Test Plan:
- Ordering, ORDER=1, N=9, DW=8: din elements 0..8 = {5,200,17,0,255,17,99,3,64}, one vin pulse. After 9 cycles vout=1 and dout slices 0..8 = {0,3,5,17,17,64,99,200,255}; dmed=17, dmax=255, dmin=0.
- Reverse order, ORDER=0: same input gives slices 0..8 = {255,200,99,64,17,17,5,3,0}; dmax=255, dmin=0.
- Stability, with WL_SORTN_INDEX_EN: all elements = 8'h80. Result is dout_idx = {0,1,…,8} and dout unchanged. For the first vector, dout_idx for the two 17s is 2 then 5.
- Streaming and stall: 20 back-to-back random vectors, then ce=0 for 5 cycles in the middle. Results match a scoreboard sort in order, with none lost or duplicated, and outputs frozen during the stall.
- Reset mid-flight: 4 vectors in flight, then rst for 1 cycle. On the next cycle vout=0 and dout=0. No stale vout appears afterwards, and a new vector emerges 9 cycles after its vin.
- Edge N=2: din = {10,3} (element 1 = 10). After 2 cycles dout = {10,3}, i.e. slice 1 = 10 and slice 0 = 3. A second vector {3,10} produces the same output.
